// File: rtl/mux_sweep_sequencer_pkg.sv
// Shared definitions for the mux sweep sequencer: FSM states, sweep geometry
// and the default golden response.
package mux_sweep_sequencer_pkg;

    localparam int unsigned STEP_W    = 4;
    localparam int unsigned SWEEP_LEN = 16;
    localparam int unsigned HOLD_W    = 4;

    localparam logic [SWEEP_LEN-1:0] DEFAULT_EXPECTED = 16'hCACA;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } sweep_state_e;

    // Step index k maps to {select, data} = {k[3:2], k[1:0]}.
    function automatic logic [1:0] sel_of(input logic [STEP_W-1:0] k);
        return k[3:2];
    endfunction

    function automatic logic [1:0] data_of(input logic [STEP_W-1:0] k);
        return k[1:0];
    endfunction

endpackage

// File: rtl/mux_sweep_sequencer_hold_timer.sv
// Hold timer: counts 0..HOLD_CYCLES-1 while enabled, wraps on terminal count,
// and can be cleared synchronously.
module hold_timer
    import mux_sweep_sequencer_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic count_i,
    output logic tc_o
);

    localparam logic [HOLD_W-1:0] LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] cnt_q;

    assign tc_o = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cnt_q <= '0;
        end else if (count_i) begin
            cnt_q <= tc_o ? '0 : cnt_q + HOLD_W'(1);
        end
    end

endmodule

// File: rtl/mux_sweep_sequencer.sv
// Sweeps all 16 select/data combinations into a downstream mux, capturing F per step.
// Optional response check against EXPECTED is enabled by defining SWEEP_CHECK_EN.
module mux_sweep_sequencer
    import mux_sweep_sequencer_pkg::*;
#(
    parameter int unsigned           HOLD_CYCLES = 4,
    parameter logic [SWEEP_LEN-1:0]  EXPECTED    = DEFAULT_EXPECTED
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [1:0]            s_out,
    output logic [1:0]            i_out,
    input  logic                  f_in,
    output logic                  busy,
    output logic                  done,
    output logic [SWEEP_LEN-1:0]  result,
    output logic [STEP_W-1:0]     step,
    output logic                  pass
);

    sweep_state_e          state_q;
    logic [STEP_W-1:0]     k_q;
    logic [1:0]            s_q;
    logic [1:0]            i_q;
    logic                  busy_q;
    logic                  done_q;
    logic [SWEEP_LEN-1:0]  result_q;
    logic [SWEEP_LEN-1:0]  result_d;
    logic [STEP_W-1:0]     k_inc;
    logic                  tc;
    logic                  launch;
    logic                  advance;
    logic                  last_step;

    assign launch    = (state_q == IDLE) && start;
    assign advance   = (state_q == DRIVE) && tc;
    assign last_step = (k_q == STEP_W'(SWEEP_LEN - 1));
    assign k_inc     = k_q + STEP_W'(1);

    // Result with the current step's response merged in, used on the capture edge.
    always_comb begin
        result_d      = result_q;
        result_d[k_q] = f_in;
    end

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .clear_i (launch),
        .count_i (state_q == DRIVE),
        .tc_o    (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            s_q      <= '0;
            i_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q  <= DRIVE;
                        k_q      <= '0;
                        s_q      <= '0;
                        i_q      <= '0;
                        busy_q   <= 1'b1;
                        result_q <= '0;
                    end
                end
                DRIVE: begin
                    if (tc) begin
                        result_q <= result_d;
                        if (last_step) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            k_q <= k_inc;
                            s_q <= sel_of(k_inc);
                            i_q <= data_of(k_inc);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    k_q     <= '0;
                    s_q     <= '0;
                    i_q     <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SWEEP_CHECK_EN
    logic pass_q;

    // Compared against the merged result so the final captured bit is included.
    always_ff @(posedge clk) begin
        if (rst || launch) begin
            pass_q <= 1'b0;
        end else if (advance && last_step) begin
            pass_q <= (result_d == EXPECTED);
        end
    end

    assign pass = pass_q;
`else
    logic unused_expected;
    assign unused_expected = ^EXPECTED;
    assign pass            = 1'b0;
`endif

    assign s_out  = s_q;
    assign i_out  = i_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign step   = k_q;

endmodule
